// File: rtl/seq_pkg.sv
// Shared state encoding and default geometry for the serial pattern sequencer.
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 6;
    localparam int unsigned DEF_DIV   = 1;
    localparam int unsigned DEF_GAP   = 2;

endpackage

// File: rtl/seq_bit_timer.sv
// Slot timer: clear loads LOAD-1, counts down while enabled, terminal count at zero.
module seq_bit_timer #(
    parameter int unsigned LOAD = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned CW = $clog2(LOAD) + 1;

    logic [CW-1:0] cnt;

    // Holds at zero once expired; the owner clears it at the start of every slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= CW'(LOAD - 1);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign tc_c = (cnt == '0);

endmodule

// File: rtl/seq_sched.sv
// Serial pattern sequencer: latches SWITCHES and shifts it out LSB-first on X.
// Build option SEQ_SCHED_PARITY_EN appends an even-parity slot after the last bit.
module seq_sched
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DIV   = DEF_DIV,
    parameter int unsigned GAP   = DEF_GAP
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic             REPEAT,
    input  logic [WIDTH-1:0] SWITCHES,
    output logic             X,
    output logic             X_VALID,
    output logic [WIDTH-1:0] LEDS,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned IW     = $clog2(WIDTH);
    localparam int unsigned GAP_LD = (GAP > 0) ? GAP : 1;

    state_t           state, state_n;
    logic [WIDTH-1:0] pattern, pattern_n;
    logic [IW-1:0]    idx, idx_n, nidx;
    logic             x_n, xv_n, busy_n, done_n;
    logic [WIDTH-1:0] leds_n;
    logic             div_clr, gap_clr, div_tc, gap_tc;
    logic             launch, last;
`ifdef SEQ_SCHED_PARITY_EN
    logic             par, par_n;
`endif

    seq_bit_timer #(.LOAD(DIV)) u_div (
        .clk   (CLK),
        .rst   (RST),
        .clear (div_clr),
        .en    (state == S_SHIFT),
        .tc_c  (div_tc)
    );

    seq_bit_timer #(.LOAD(GAP_LD)) u_gap (
        .clk   (CLK),
        .rst   (RST),
        .clear (gap_clr),
        .en    (state == S_GAP),
        .tc_c  (gap_tc)
    );

    assign nidx = idx + IW'(1);
`ifdef SEQ_SCHED_PARITY_EN
    assign last = par;
`else
    assign last = (idx == IW'(WIDTH - 1));
`endif

    // Next state plus next-cycle output values; outputs are registered from these.
    always_comb begin
        state_n   = state;
        pattern_n = pattern;
        idx_n     = idx;
        x_n       = 1'b0;
        xv_n      = 1'b0;
        leds_n    = '0;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        div_clr   = 1'b0;
        gap_clr   = 1'b0;
        launch    = 1'b0;
`ifdef SEQ_SCHED_PARITY_EN
        par_n     = par;
`endif

        case (state)
            S_IDLE: begin
                if (START) begin
                    launch = 1'b1;
                end
            end
            S_SHIFT: begin
                busy_n = 1'b1;
                if (div_tc) begin
                    if (last) begin
                        done_n = 1'b1;
                        busy_n = 1'b0;
                        if (REPEAT) begin
                            if (GAP > 0) begin
                                state_n = S_GAP;
                                gap_clr = 1'b1;
                                busy_n  = 1'b1;
                            end else begin
                                launch = 1'b1;
                            end
                        end else begin
                            state_n = S_IDLE;
                        end
                    end
`ifdef SEQ_SCHED_PARITY_EN
                    else if (idx == IW'(WIDTH - 1)) begin
                        par_n   = 1'b1;
                        div_clr = 1'b1;
                        x_n     = ^pattern;
                        xv_n    = 1'b1;
                    end
`endif
                    else begin
                        idx_n   = nidx;
                        div_clr = 1'b1;
                        x_n     = pattern[nidx];
                        xv_n    = 1'b1;
                        leds_n  = WIDTH'(1) << nidx;
                    end
                end else begin
                    xv_n = 1'b1;
`ifdef SEQ_SCHED_PARITY_EN
                    x_n    = par ? ^pattern : pattern[idx];
                    leds_n = par ? '0 : (WIDTH'(1) << idx);
`else
                    x_n    = pattern[idx];
                    leds_n = WIDTH'(1) << idx;
`endif
                end
            end
            S_GAP: begin
                busy_n = 1'b1;
                if (gap_tc) begin
                    launch = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // New pattern: bit0 is presented straight after the latching edge.
        if (launch) begin
            state_n   = S_SHIFT;
            pattern_n = SWITCHES;
            idx_n     = '0;
            div_clr   = 1'b1;
            x_n       = SWITCHES[0];
            xv_n      = 1'b1;
            leds_n    = WIDTH'(1);
            busy_n    = 1'b1;
`ifdef SEQ_SCHED_PARITY_EN
            par_n     = 1'b0;
`endif
        end

        // Abort wins over everything, including a pending DONE.
        if (STOP) begin
            state_n = S_IDLE;
            idx_n   = '0;
            x_n     = 1'b0;
            xv_n    = 1'b0;
            leds_n  = '0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
`ifdef SEQ_SCHED_PARITY_EN
            par_n   = 1'b0;
`endif
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            pattern <= '0;
            idx     <= '0;
            X       <= 1'b0;
            X_VALID <= 1'b0;
            LEDS    <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
`ifdef SEQ_SCHED_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            pattern <= pattern_n;
            idx     <= idx_n;
            X       <= x_n;
            X_VALID <= xv_n;
            LEDS    <= leds_n;
            BUSY    <= busy_n;
            DONE    <= done_n;
`ifdef SEQ_SCHED_PARITY_EN
            par     <= par_n;
`endif
        end
    end

endmodule

// File: doc/seq_sched.md
Name: seq_sched

Overview:
- Controller that sequences the serial bit-driver path: latches a WIDTH-bit switch pattern and emits it LSB-first on X.
- Each bit is held for a programmable number of clocks and qualified by X_VALID, with a one-hot LED position marker.
- Supports single-shot or continuous repeat with an inter-pattern gap; STOP aborts.
- Sits between the board switches and the FSM sequence detector under test.

Parameters:
- WIDTH, 6, pattern length in bits (2..8).
- DIV, 1, clock cycles each bit is held (>=1).
- GAP, 2, idle cycles between repeated patterns (0 = back-to-back).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  level-sampled request to begin a pattern; honoured only in IDLE.
- STOP  in  1  abort; returns to IDLE from any state.
- REPEAT  in  1  sampled at pattern end: 1 = loop, 0 = stop.
- SWITCHES  in  WIDTH  pattern source; latched at start of each pattern.
- X  out  1  serial data bit.
- X_VALID  out  1  X carries a pattern bit this cycle.
- LEDS  out  WIDTH  one-hot current bit position.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse after the final bit of each pattern.

Behaviour:
- All outputs registered.
- Reset (async, RST=1):
  - state=IDLE, pattern=0, idx=0, divcnt=0, gapcnt=0.
  - X=0, X_VALID=0, LEDS=0, BUSY=0, DONE=0.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - On an edge with START=1 and STOP=0: pattern<=SWITCHES, idx<=0, divcnt<=0, go to SHIFT.
  - Bit0 is visible after that same edge: zero-cycle latency from the START sample.
- SHIFT:
  - X=pattern[idx], X_VALID=1, LEDS=1<<idx, BUSY=1.
  - divcnt counts 0..DIV-1. When divcnt=DIV-1 and idx<WIDTH-1: idx++, divcnt<=0.
  - When divcnt=DIV-1 and idx=WIDTH-1 (pattern end): DONE<=1 for exactly one cycle, X_VALID<=0, LEDS<=0.
- Pattern end, REPEAT=1, GAP>0: go to GAP, gapcnt<=0.
- Pattern end, REPEAT=1, GAP=0: re-latch SWITCHES and restart at idx 0. In this case DONE and X_VALID=1 for bit0 are in the same cycle.
- Pattern end, REPEAT=0: go to IDLE.
- GAP:
  - X_VALID=0, LEDS=0, X=0, BUSY=1.
  - When gapcnt=GAP-1: re-latch SWITCHES, go to SHIFT idx 0.
- STOP=1 on any edge: go to IDLE next edge. All outputs take reset values, with no DONE. STOP has priority over START, REPEAT and pattern end.
- START while BUSY is ignored.
- SWITCHES changes mid-pattern have no effect until the next latch.
- X=0 whenever X_VALID=0.
- idx width = clog2(WIDTH); divcnt width = clog2(DIV)+1. No wrap beyond the terminal values.
- RST asserted mid-pattern: immediate return to reset values; DONE never fires.

Optional Feature:
- Macro SEQ_SCHED_PARITY_EN.
- Defined:
  - After bit WIDTH-1, one extra SHIFT slot of DIV cycles with X = ^pattern (even-parity bit), X_VALID=1, LEDS=0.
  - DONE follows the parity slot.
- Undefined: no parity slot; pattern length is exactly WIDTH bits.

Decomposition:
- Shared package seq_pkg holds:
  - State encodings S_IDLE=2'd0, S_SHIFT=2'd1, S_GAP=2'd2.
  - Default WIDTH/DIV/GAP constants.
- One natural sub-module: seq_bit_timer.
  - DIV down-counter with clear input and terminal-count output.
  - Reused for gap timing with GAP as its load value.

Test Plan:
- Single shot, WIDTH=6, DIV=1, REPEAT=0, SWITCHES=6'b101101, START for 1 cycle:
  - X=1,0,1,1,0,1 on cycles 0..5.
  - LEDS=01,02,04,08,10,20 on the same cycles.
  - DONE=1 on cycle 6, then IDLE with BUSY=0.
- DIV=3, SWITCHES=6'b000001: X=1 for 3 cycles, then 0 for 15 cycles, then DONE on cycle 18.
- REPEAT=1, GAP=2, SWITCHES changed from 6'h2A to 6'h15 mid-pattern:
  - First pattern emits 0,1,0,1,0,1.
  - Then 2 cycles with X_VALID=0.
  - Second pattern emits 1,0,1,0,1,0.
- STOP asserted at idx=3: next cycle X_VALID=0, LEDS=0, BUSY=0, and no DONE pulse. START re-issued during SHIFT is ignored.
- RST asserted asynchronously mid-bit: outputs go to 0 without waiting for a clock edge. After release, START resumes normally.
- With SEQ_SCHED_PARITY_EN, SWITCHES=6'b000111: 7th slot X=1 with LEDS=0, and DONE on the following cycle.
